// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus definitions for the rv32soc native memory port.
// Widths, timeout read pattern and arbiter state encoding.
package rv32soc_bus_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = 4;

  localparam logic [MEM_DATA_W-1:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Arbiter bus bundle: per-master request side plus shared slave port.
// master = arbiter view, slave = environment view.
interface mem_bus_arbiter_if
  import rv32soc_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2
);

  logic [NUM_MASTERS-1:0]            m_valid;
  logic [NUM_MASTERS-1:0]            m_instr;
  logic [NUM_MASTERS*MEM_ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*MEM_DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS*MEM_STRB_W-1:0] m_wstrb;
  logic [NUM_MASTERS-1:0]            m_ready;
  logic [NUM_MASTERS-1:0]            m_error;
  logic [MEM_DATA_W-1:0]             m_rdata;

  logic                  s_valid;
  logic                  s_instr;
  logic [MEM_ADDR_W-1:0] s_addr;
  logic [MEM_DATA_W-1:0] s_wdata;
  logic [MEM_STRB_W-1:0] s_wstrb;
  logic                  s_ready;
  logic [MEM_DATA_W-1:0] s_rdata;

  modport master (
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    output m_ready, m_error, m_rdata,
    output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport slave (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_error, m_rdata,
    input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first set req bit
// searching upward from (last+1) mod NUM_MASTERS.
module mem_rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int LW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [LW-1:0]          last,
  output logic                   found,
  output logic [LW-1:0]          idx
);

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      int j;
      j = (int'(last) + k) % NUM_MASTERS;
      if (req[j]) begin
        found = 1'b1;
        idx   = LW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native memory port among masters,
// with a per-transaction watchdog against hung slaves.
module mem_bus_arbiter
  import rv32soc_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              resetn,
  mem_bus_arbiter_if.master bus
);

  localparam int LW = $clog2(NUM_MASTERS);
  localparam int CW =
    (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  arb_state_t state;
  logic [LW-1:0] grant;
  logic [LW-1:0] lastGrant;
  logic [CW-1:0] cnt;

  logic          found;
  logic [LW-1:0] pickIdx;

  mem_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) uPick (
    .req  (bus.m_valid),
    .last (lastGrant),
    .found(found),
    .idx  (pickIdx)
  );

  int unsigned gIdx;
  logic [NUM_MASTERS-1:0] grantOh;
  logic busy, active, done, tout;

  assign gIdx    = 32'(grant);
  assign grantOh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant;
  assign busy    = (state == ARB_BUSY);
  // A dropped request aborts silently: no slave request, no completion.
  assign active  = busy && bus.m_valid[grant];
  assign done    = active && bus.s_ready;
  assign tout    = active && !bus.s_ready && WD_EN && (cnt == TLAST);

  assign bus.s_valid = active && !tout;
  assign bus.s_instr = bus.s_valid && bus.m_instr[grant];
  assign bus.s_addr  = bus.s_valid ?
    bus.m_addr[gIdx*MEM_ADDR_W +: MEM_ADDR_W] : '0;
  assign bus.s_wdata = bus.s_valid ?
    bus.m_wdata[gIdx*MEM_DATA_W +: MEM_DATA_W] : '0;
  assign bus.s_wstrb = bus.s_valid ?
    bus.m_wstrb[gIdx*MEM_STRB_W +: MEM_STRB_W] : '0;

  assign bus.m_ready = (done || tout) ? grantOh : '0;
  assign bus.m_error = tout ? grantOh : '0;
  assign bus.m_rdata = done ? bus.s_rdata :
                       tout ? TIMEOUT_RDATA : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      lastGrant <= LW'(NUM_MASTERS - 1);
      cnt       <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (found) begin
            grant     <= pickIdx;
            lastGrant <= pickIdx;
            cnt       <= '0;
            state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!active || bus.s_ready || tout) begin
            state <= ARB_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (2 masters, 8-cycle watchdog).
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.NUM_MASTERS(2)) bus ();

  mem_bus_arbiter #(
    .NUM_MASTERS(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_valid = 2'b00;
    bus.m_instr = 2'b00;
    bus.m_addr  = {32'h0000_2000, 32'h0000_0100};
    bus.m_wdata = {32'h1111_2222, 32'hCAFE_BABE};
    bus.m_wstrb = {4'h0, 4'hF};
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.m_valid = 2'b11;
    resetn = 1'b0;
    cyc(); cyc(); cyc();
    settle();
    checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got=%b want=0", bus.s_valid); end
    checks++; if (bus.m_ready !== 2'b00) begin errors++; $display("FAIL reset_m_ready got=%b want=00", bus.m_ready); end
    checks++; if (bus.m_error !== 2'b00) begin errors++; $display("FAIL reset_m_error got=%b want=00", bus.m_error); end
    checks++; if (bus.s_wstrb !== 4'h0) begin errors++; $display("FAIL reset_s_wstrb got=%h want=0", bus.s_wstrb); end
    checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got=%h want=0", bus.m_rdata); end
    bus.m_valid = 2'b00;
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    idle_inputs();
    bus.m_valid = 2'b01;
    settle();
    checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL single_c0_s_valid got=%b want=0", bus.s_valid); end
    cyc();
    checks++; if (bus.s_valid !== 1'b1) begin errors++; $display("FAIL single_c1_s_valid got=%b want=1", bus.s_valid); end
    checks++; if (bus.s_addr !== 32'h100) begin errors++; $display("FAIL single_s_addr got=%h want=100", bus.s_addr); end
    checks++; if (bus.s_wdata !== 32'hCAFEBABE) begin errors++; $display("FAIL single_s_wdata got=%h want=cafebabe", bus.s_wdata); end
    checks++; if (bus.s_wstrb !== 4'hF) begin errors++; $display("FAIL single_s_wstrb got=%h want=f", bus.s_wstrb); end
    cyc(); cyc();
    checks++; if (bus.m_ready !== 2'b00) begin errors++; $display("FAIL single_c3_m_ready got=%b want=00", bus.m_ready); end
    cyc();
    bus.s_ready = 1'b1;
    settle();
    checks++; if (bus.m_ready !== 2'b01) begin errors++; $display("FAIL single_c4_m_ready got=%b want=01", bus.m_ready); end
    checks++; if (bus.m_error !== 2'b00) begin errors++; $display("FAIL single_c4_m_error got=%b want=00", bus.m_error); end
    cyc();
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b00;
    settle();
    checks++; if (bus.s_valid !== 1'b0 || bus.m_ready !== 2'b00) begin errors++; $display("FAIL single_c5_idle got=%b/%b want=0/00", bus.s_valid, bus.m_ready); end
  endtask

  task automatic test_contention();
    logic [31:0] expAddr;
    logic [1:0] expOh;
    do_reset();
    idle_inputs();
    bus.m_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      expAddr = (k % 2 == 0) ? 32'h100 : 32'h2000;
      expOh = (k % 2 == 0) ? 2'b01 : 2'b10;
      cyc();
      checks++; if (bus.s_valid !== 1'b1 || bus.s_addr !== expAddr) begin errors++; $display("FAIL cont_grant%0d got=%b/%h want=1/%h", k, bus.s_valid, bus.s_addr, expAddr); end
      cyc();
      bus.s_ready = 1'b1;
      settle();
      checks++; if (bus.m_ready !== expOh) begin errors++; $display("FAIL cont_ready%0d got=%b want=%b", k, bus.m_ready, expOh); end
      cyc();
      bus.s_ready = 1'b0;
      settle();
      checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL cont_gap%0d got=%b want=0", k, bus.s_valid); end
    end
    bus.m_valid = 2'b00;
    cyc();
  endtask

  task automatic test_read_data();
    idle_inputs();
    bus.m_valid = 2'b10;
    bus.s_rdata = 32'h1234_5678;
    cyc();
    checks++; if (bus.s_addr !== 32'h2000 || bus.s_wstrb !== 4'h0) begin errors++; $display("FAIL rd_req got=%h/%h want=2000/0", bus.s_addr, bus.s_wstrb); end
    checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL rd_before got=%h want=0", bus.m_rdata); end
    cyc();
    bus.s_ready = 1'b1;
    settle();
    checks++; if (bus.m_ready !== 2'b10 || bus.m_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got=%b/%h want=10/12345678", bus.m_ready, bus.m_rdata); end
    cyc();
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b00;
    settle();
    checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL rd_after got=%h want=0", bus.m_rdata); end
    cyc();
  endtask

  task automatic test_timeout();
    idle_inputs();
    bus.m_valid = 2'b01;
    bus.s_rdata = 32'hA5A5_A5A5;
    for (int c = 1; c <= 7; c++) cyc();
    checks++; if (bus.s_valid !== 1'b1 || bus.m_ready !== 2'b00) begin errors++; $display("FAIL to_c7 got=%b/%b want=1/00", bus.s_valid, bus.m_ready); end
    cyc();
    checks++; if (bus.m_ready !== 2'b01 || bus.m_error !== 2'b01) begin errors++; $display("FAIL to_c8_flags got=%b/%b want=01/01", bus.m_ready, bus.m_error); end
    checks++; if (bus.m_rdata !== 32'hFFFF_FFFF || bus.s_valid !== 1'b0) begin errors++; $display("FAIL to_c8_data got=%h/%b want=ffffffff/0", bus.m_rdata, bus.s_valid); end
    cyc();
    checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL to_idle got=%b want=0", bus.s_valid); end
    cyc();
    checks++; if (bus.s_valid !== 1'b1) begin errors++; $display("FAIL to_regrant got=%b want=1", bus.s_valid); end
    for (int c = 2; c <= 8; c++) cyc();
    bus.s_ready = 1'b1;
    settle();
    checks++; if (bus.m_ready !== 2'b01 || bus.m_error !== 2'b00) begin errors++; $display("FAIL to_tie_flags got=%b/%b want=01/00", bus.m_ready, bus.m_error); end
    checks++; if (bus.m_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL to_tie_data got=%h want=a5a5a5a5", bus.m_rdata); end
    cyc();
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b00;
    cyc();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.m_valid = 2'b10;
    cyc();
    checks++; if (bus.s_valid !== 1'b1 || bus.s_addr !== 32'h2000) begin errors++; $display("FAIL rst_busy got=%b/%h want=1/2000", bus.s_valid, bus.s_addr); end
    cyc();
    resetn = 1'b0;
    cyc();
    checks++; if (bus.s_valid !== 1'b0 || bus.m_ready !== 2'b00) begin errors++; $display("FAIL rst_drop got=%b/%b want=0/00", bus.s_valid, bus.m_ready); end
    resetn = 1'b1;
    bus.m_valid = 2'b11;
    cyc();
    checks++; if (bus.s_valid !== 1'b1 || bus.s_addr !== 32'h100) begin errors++; $display("FAIL rst_first got=%b/%h want=1/100", bus.s_valid, bus.s_addr); end
    bus.s_ready = 1'b1;
    settle();
    checks++; if (bus.m_ready !== 2'b01) begin errors++; $display("FAIL rst_first_ready got=%b want=01", bus.m_ready); end
    cyc();
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b00;
    cyc();
  endtask

  task automatic test_valid_drop();
    idle_inputs();
    bus.m_valid = 2'b10;
    cyc();
    checks++; if (bus.s_valid !== 1'b1) begin errors++; $display("FAIL drop_busy got=%b want=1", bus.s_valid); end
    cyc();
    bus.m_valid = 2'b00;
    bus.s_ready = 1'b1;
    settle();
    checks++; if (bus.s_valid !== 1'b0 || bus.m_ready !== 2'b00) begin errors++; $display("FAIL drop_same got=%b/%b want=0/00", bus.s_valid, bus.m_ready); end
    cyc();
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b10;
    settle();
    checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL drop_idle got=%b want=0", bus.s_valid); end
    cyc();
    checks++; if (bus.s_valid !== 1'b1) begin errors++; $display("FAIL drop_regrant got=%b want=1", bus.s_valid); end
    bus.s_ready = 1'b1;
    settle();
    checks++; if (bus.m_ready !== 2'b10) begin errors++; $display("FAIL drop_ready got=%b want=10", bus.m_ready); end
    cyc();
    idle_inputs();
    cyc();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_read_data();
    test_timeout();
    test_reset_mid();
    test_valid_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
